// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the DataPath.
// master = sequencer side, slave = DataPath side.
interface control_sequencer_if #(
  parameter int REGS = 16
);
  logic            run;
  logic            mem_ready;
  logic [31:0]     IR;
  logic            PCout;
  logic            Zlowout;
  logic            MDRout;
  logic            MARin;
  logic            PCin;
  logic            MDRin;
  logic            IRin;
  logic            Yin;
  logic            Zin_low;
  logic            IncPC;
  logic            Read;
  logic [REGS-1:0] R_in;
  logic [REGS-1:0] R_out;
  logic [3:0]      operation;
  logic            halted;
  logic            illegal;
  logic [3:0]      state_dbg;

  modport master (
    input  run, mem_ready, IR,
    output PCout, Zlowout, MDRout,
    output MARin, PCin, MDRin, IRin,
    output Yin, Zin_low, IncPC, Read,
    output R_in, R_out, operation,
    output halted, illegal, state_dbg
  );

  modport slave (
    output run, mem_ready, IR,
    input  PCout, Zlowout, MDRout,
    input  MARin, PCin, MDRin, IRin,
    input  Yin, Zin_low, IncPC, Read,
    input  R_in, R_out, operation,
    input  halted, illegal, state_dbg
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0..T2, ALU/shift T3..T5.
// Halts on the halt opcode or any illegal opcode.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int REGS = 16
) (
  input logic             Clock,
  input logic             clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [REGS-1:0] ONE =
    {{(REGS-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic           illegal_q, illegal_d;
  logic [OPW-1:0] opcode;
  logic [3:0]     ra, rb, rc;
  logic [3:0]     alu_code;
  logic           is_alu, is_nop, is_halt;

  assign opcode = bus.IR[31 -: OPW];
  assign ra     = bus.IR[26:23];
  assign rb     = bus.IR[22:19];
  assign rc     = bus.IR[18:15];

  assign bus.halted    = (state_q == S_HALT);
  assign bus.illegal   = illegal_q;
  assign bus.state_dbg = state_q;

  // Opcode decode into instruction class and ALU function
  always_comb begin
    is_alu   = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    alu_code = 4'b0000;
    unique case (opcode)
      5'b00011: begin is_alu = 1'b1; alu_code = 4'b0011; end
      5'b00100: begin is_alu = 1'b1; alu_code = 4'b0100; end
      5'b00101: begin is_alu = 1'b1; alu_code = 4'b0101; end
      5'b00110: begin is_alu = 1'b1; alu_code = 4'b0110; end
      5'b00111: begin is_alu = 1'b1; alu_code = 4'b0111; end
      5'b01000: begin is_alu = 1'b1; alu_code = 4'b1100; end
      5'b01001: begin is_alu = 1'b1; alu_code = 4'b1001; end
      5'b01010: begin is_alu = 1'b1; alu_code = 4'b1010; end
      5'b01011: begin is_alu = 1'b1; alu_code = 4'b1011; end
      5'b11000: is_nop  = 1'b1;
      5'b11001: is_halt = 1'b1;
      default:  ;
    endcase
  end

  // Next-state and Moore control outputs
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin_low   = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.R_in      = '0;
    bus.R_out     = '0;
    bus.operation = 4'b0000;
    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      S_T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin_low = 1'b1;
        state_d     = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        state_d     = bus.mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        unique case (1'b1)
          is_alu: begin
            bus.R_out = ONE << rb;
            bus.Yin   = 1'b1;
            state_d   = S_T4;
          end
          is_nop: begin
            state_d = bus.run ? S_T0 : S_IDLE;
          end
          is_halt: begin
            state_d = S_HALT;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_T4: begin
        bus.R_out     = ONE << rc;
        bus.Zin_low   = 1'b1;
        bus.operation = alu_code;
        state_d       = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.R_in    = ONE << ra;
        state_d     = bus.run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and sticky illegal flag
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle model compare
// plus directed literal checks.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear;

  control_sequencer_if #(.REGS(16)) bus ();

  control_sequencer #(
    .OPW(5),
    .REGS(16)
  ) dut (
    .Clock(Clock),
    .clear(clear),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of an instruction, named by what happens.
  typedef enum int {
    M_IDLE, M_ADDR, M_READ, M_WAIT, M_LOAD,
    M_OPA, M_OPB, M_WB, M_HALT
  } mph_t;

  mph_t m_ph  = M_IDLE;
  logic m_ill = 1'b0;

  // 0 = alu, 1 = nop, 2 = halt, 3 = illegal
  function automatic int kind(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    if (op >= 3 && op <= 11) return 0;
    if (op == 24) return 1;
    if (op == 25) return 2;
    return 3;
  endfunction

  function automatic logic [3:0] alu_fn(input logic [31:0] ir);
    logic [4:0] op;
    op = ir[31:27];
    return (op == 5'd8) ? 4'hC : op[3:0];
  endfunction

  function automatic logic [3:0] enc(input mph_t p);
    case (p)
      M_IDLE:  return 4'd0;
      M_ADDR:  return 4'd1;
      M_READ:  return 4'd2;
      M_WAIT:  return 4'd3;
      M_LOAD:  return 4'd4;
      M_OPA:   return 4'd5;
      M_OPB:   return 4'd6;
      M_WB:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      m_ph  <= M_IDLE;
      m_ill <= 1'b0;
    end else begin
      case (m_ph)
        M_IDLE: if (bus.run) m_ph <= M_ADDR;
        M_ADDR: m_ph <= M_READ;
        M_READ: m_ph <= bus.mem_ready ? M_LOAD : M_WAIT;
        M_WAIT: if (bus.mem_ready) m_ph <= M_LOAD;
        M_LOAD: m_ph <= M_OPA;
        M_OPA: begin
          case (kind(bus.IR))
            0: m_ph <= M_OPB;
            1: m_ph <= bus.run ? M_ADDR : M_IDLE;
            2: m_ph <= M_HALT;
            default: begin
              m_ph  <= M_HALT;
              m_ill <= 1'b1;
            end
          endcase
        end
        M_OPB: m_ph <= M_WB;
        M_WB:  m_ph <= bus.run ? M_ADDR : M_IDLE;
        default: m_ph <= M_HALT;
      endcase
    end
  end

  function automatic logic [52:0] exp_vec();
    logic pco, zlo, mdro, mar, pci, mdri;
    logic iri, yin, zin, inc, rd, hlt;
    logic [15:0] rin, rout;
    logic [3:0]  op;
    logic [3:0]  ra, rb, rc;
    ra = bus.IR[26:23];
    rb = bus.IR[22:19];
    rc = bus.IR[18:15];
    {pco, zlo, mdro, mar, pci, mdri} = '0;
    {iri, yin, zin, inc, rd, hlt} = '0;
    rin = '0;
    rout = '0;
    op = '0;
    case (m_ph)
      M_ADDR: begin pco = 1; mar = 1; inc = 1; zin = 1; end
      M_READ: begin zlo = 1; pci = 1; rd = 1; mdri = 1; end
      M_WAIT: begin rd = 1; mdri = 1; end
      M_LOAD: begin mdro = 1; iri = 1; end
      M_OPA: if (kind(bus.IR) == 0) begin
        rout = 16'd1 << rb;
        yin  = 1;
      end
      M_OPB: begin
        rout = 16'd1 << rc;
        zin  = 1;
        op   = alu_fn(bus.IR);
      end
      M_WB: begin zlo = 1; rin = 16'd1 << ra; end
      M_HALT: hlt = 1;
      default: ;
    endcase
    return {pco, zlo, mdro, mar, pci, mdri, iri, yin,
            zin, inc, rd, rin, rout, op, hlt, m_ill,
            enc(m_ph)};
  endfunction

  function automatic logic [52:0] act_vec();
    return {bus.PCout, bus.Zlowout, bus.MDRout,
            bus.MARin, bus.PCin, bus.MDRin, bus.IRin,
            bus.Yin, bus.Zin_low, bus.IncPC, bus.Read,
            bus.R_in, bus.R_out, bus.operation,
            bus.halted, bus.illegal, bus.state_dbg};
  endfunction

  // Per-cycle compare on the falling edge
  always @(negedge Clock) begin
    check($sformatf("cycle phase=%0d", int'(m_ph)),
          64'(act_vec()), 64'(exp_vec()));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  initial begin
    clear = 1'b1;
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    bus.IR = 32'h0;
    #1 clear = 1'b0;
    tick();
    tick();
    check("rst_state", 64'(bus.state_dbg), 64'd0);
    check("rst_outs", 64'(act_vec()), 64'd0);

    // fetch + and R1,R2,R3
    clear = 1'b1;
    bus.IR = 32'h28918000;
    tick();
    check("t0_state", 64'(bus.state_dbg), 64'd1);
    check("t0_ctl", 64'({bus.PCout, bus.MARin,
          bus.IncPC, bus.Zin_low}), 64'hF);
    tick();
    check("t1_state", 64'(bus.state_dbg), 64'd2);
    tick();
    tick();
    check("and_t3_rout", 64'(bus.R_out), 64'h0004);
    check("and_t3_yin", 64'(bus.Yin), 64'd1);
    tick();
    check("and_t4_rout", 64'(bus.R_out), 64'h0008);
    check("and_t4_op", 64'(bus.operation), 64'h5);
    check("and_t4_zin", 64'(bus.Zin_low), 64'd1);
    tick();
    check("and_t5_rin", 64'(bus.R_in), 64'h0002);
    check("and_t5_zlo", 64'(bus.Zlowout), 64'd1);
    tick();
    check("and_next_t0", 64'(bus.state_dbg), 64'd1);

    // memory wait, then shra R1,R4,R7
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1w_state", 64'(bus.state_dbg), 64'd3);
      check("t1w_ctl", 64'({bus.Read, bus.MDRin,
            bus.PCin}), 64'b110);
      if (i == 2) bus.mem_ready = 1'b1;
    end
    tick();
    check("t1w_to_t2", 64'(bus.state_dbg), 64'd4);
    bus.IR = 32'h40A38000;
    tick();
    check("shra_t3_rout", 64'(bus.R_out), 64'h0010);
    tick();
    check("shra_t4_op", 64'(bus.operation), 64'hC);
    check("shra_t4_rout", 64'(bus.R_out), 64'h0080);
    tick();
    check("shra_t5_rin", 64'(bus.R_in), 64'h0002);
    tick();

    // nop
    bus.IR = 32'hC0000000;
    tick();
    tick();
    tick();
    check("nop_t3_rout", 64'(bus.R_out), 64'h0);
    check("nop_t3_yin", 64'(bus.Yin), 64'd0);
    tick();
    check("nop_to_t0", 64'(bus.state_dbg), 64'd1);

    // add R5,R5,R5
    bus.IR = 32'h1AAA8000;
    tick();
    tick();
    tick();
    check("same_t3_rout", 64'(bus.R_out), 64'h0020);
    tick();
    check("same_t4_rout", 64'(bus.R_out), 64'h0020);
    check("same_t4_op", 64'(bus.operation), 64'h3);
    tick();
    check("same_t5_rin", 64'(bus.R_in), 64'h0020);
    tick();

    // halt opcode
    bus.IR = 32'hC8000000;
    tick();
    tick();
    tick();
    tick();
    check("halt_state", 64'(bus.state_dbg), 64'd8);
    check("halt_flags", 64'({bus.halted, bus.illegal}),
          64'b10);
    repeat (3) tick();
    check("halt_stays", 64'(bus.state_dbg), 64'd8);
    clear = 1'b0;
    #1;
    check("halt_clr", 64'({bus.halted, bus.illegal,
          bus.state_dbg}), 64'd0);
    tick();
    clear = 1'b1;

    // illegal opcode 11111
    bus.IR = 32'hF8000000;
    repeat (5) tick();
    check("ill_flags", 64'({bus.halted, bus.illegal}),
          64'b11);
    clear = 1'b0;
    #1;
    check("ill_clr", 64'({bus.halted, bus.illegal,
          bus.state_dbg}), 64'd0);
    tick();
    clear = 1'b1;

    // run dropped during T4
    bus.IR = 32'h18918000;
    repeat (5) tick();
    check("drop_t4", 64'(bus.state_dbg), 64'd6);
    bus.run = 1'b0;
    tick();
    check("drop_t5", 64'(bus.state_dbg), 64'd7);
    check("drop_t5_rin", 64'(bus.R_in), 64'h0002);
    tick();
    check("drop_idle", 64'(bus.state_dbg), 64'd0);
    tick();
    check("drop_idle2", 64'(bus.state_dbg), 64'd0);

    // clear during T1W
    bus.run = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    tick();
    check("clrw_t1w", 64'(bus.state_dbg), 64'd3);
    clear = 1'b0;
    #1;
    check("clrw_state", 64'(bus.state_dbg), 64'd0);
    check("clrw_read", 64'(bus.Read), 64'd0);
    tick();
    clear = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Upstream control stage that drives the DataPath control inputs for the fetch cycle and for three-register ALU/shift instructions.
- Replaces hand-sequenced benches with a Moore FSM. It steps T0..T5 from the IR fields, waits on memory for the instruction fetch, and halts on the halt opcode or an illegal opcode.

Parameters:
- OPW, 5, opcode field width, IR[31:27]
- REGS, 16, number of general registers; width of the one-hot R_in/R_out buses

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  start/continue enable
- mem_ready  in  1  memory has data valid for the MDR during the fetch read
- IR  in  32  DataPath instruction register contents; valid from T3 onward
- PCout, Zlowout, MDRout  out  1 each  bus drive enables
- MARin, PCin, MDRin, IRin, Yin, Zin_low  out  1 each  register load enables
- IncPC, Read  out  1 each  PC increment request and memory read request
- R_in  out  16  one-hot register load; bit n = Rn
- R_out  out  16  one-hot register bus drive; bit n = Rn
- operation  out  4  ALU function select
- halted  out  1  FSM in HALT
- illegal  out  1  sticky flag: HALT was entered through an illegal opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Clocking and reset:
  - One clock. clear=0 forces IDLE asynchronously and clears illegal.
  - While in reset and in IDLE, every output is 0 and operation=4'b0000.
  - All control outputs decode combinationally from the state register plus IR; there are no output registers.
- State encoding: IDLE=0, T0=1, T1=2, T1W=3, T2=4, T3=5, T4=6, T5=7, HALT=8.
- IDLE: go to T0 when run=1, otherwise stay in IDLE.
- T0: assert PCout, MARin, IncPC, Zin_low. Go to T1.
- T1: assert Zlowout, PCin, Read, MDRin.
  - mem_ready=1: go to T2.
  - mem_ready=0: go to T1W.
- T1W: assert Read and MDRin only. PCin is not repeated. Stay in T1W until mem_ready=1, then go to T2. There is no timeout.
- T2: assert MDRout, IRin. Go to T3.
- IR fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcode to operation map:
  - 00011 add -> 0011
  - 00100 sub -> 0100
  - 00101 and -> 0101
  - 00110 or -> 0110
  - 00111 shr -> 0111
  - 01000 shra -> 1100
  - 01001 shl -> 1001
  - 01010 ror -> 1010
  - 01011 rol -> 1011
  - 11000 nop; 11001 halt; every other opcode is illegal.
- T3, by opcode:
  - ALU opcode: R_out[Rb]=1, Yin=1, go to T4.
  - nop: no outputs asserted; go to T0 if run=1, else IDLE.
  - halt: go to HALT.
  - illegal: set illegal, go to HALT.
- T4: R_out[Rc]=1, Zin_low=1, operation=mapped code. Go to T5. In every other state operation=0000.
- T5: Zlowout=1, R_in[Ra]=1. Go to T0 if run=1, else IDLE.
- HALT: halted=1, all other control outputs 0. Leave HALT only through clear.
- run is sampled only in IDLE, in T5, and in T3 for nop. Dropping run mid-instruction does not abort it.
- One-hot invariants: at most one bit of R_in and one bit of R_out is set in any cycle. R_out is 0 outside T3/T4; R_in is 0 outside T5.
- Same-register case: Ra=Rb=Rc is legal. The sequence is unchanged, because the reads (T3/T4) precede the write (T5).
- Reset mid-operation: clear low in any state returns the FSM to IDLE within the same cycle, with outputs 0. The IR contents are ignored until the next T3.

Test Plan:
- Reset: clear=0 for 2 cycles with run=1 -> state_dbg=0 and all outputs 0. Release clear -> next edge T0 with PCout=MARin=IncPC=Zin_low=1.
- Fetch plus and: mem_ready=1, IR=32'h28918000 ->
  - T3: R_out=16'h0004, Yin=1
  - T4: R_out=16'h0008, operation=4'b0101, Zin_low=1
  - T5: R_in=16'h0002, Zlowout=1
  - then T0 again.
- Memory wait: mem_ready=0 for 3 cycles after T1 -> three T1W cycles with Read=MDRin=1 and PCin=0; T2 follows the cycle mem_ready=1.
- shra: IR=32'h40A38000 (shra R1,R4,R7) -> T4 operation=4'b1100, R_out=16'h0080; T5 R_in=16'h0002.
- Halt and illegal cases:
  - IR opcode 11001 -> HALT, halted=1, illegal=0; it stays there with run=1.
  - Opcode 11111 -> halted=1, illegal=1.
  - Pulse clear -> both flags 0, IDLE.
- run dropped during T4 -> instruction completes T5, then IDLE. Asserting clear during T1W -> immediate IDLE, Read=0.
